pixel_plot_sink: RTL and testbench

Receiving end of the pixel plot stream (plot/x/y/colour) produced by the sprite drawers and the erase/update logic. Incoming pixels are clipped to the screen, buffered in a small FIFO and drained into the on-chip 160x120x3 framebuffer through a ready-gated write port. Status counters and sticky flags are exported for the game FSM.

---
 rtl/pixel_plot_sink.sv | 174 +++++++++++++++++
 tb/tb_pixel_plot_sink.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_plot_sink.sv
// Plot-stream sink: clips incoming pixels, queues them in a small FIFO and writes them into the framebuffer.
// Define COLLISION_DETECT_EN to read each target pixel before writing it and flag overdraws.
module pixel_plot_sink #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int DEPTH    = 8
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        plot,
   input  logic [7:0]  x_in,
   input  logic [6:0]  y_in,
   input  logic [2:0]  colour_in,
   output logic        full,
   output logic        idle,
   input  logic        fb_ready,
   output logic [14:0] fb_addr,
   output logic [2:0]  fb_wdata,
   output logic        fb_we,
   output logic        fb_re,
   input  logic [2:0]  fb_rdata,
   input  logic        clear_flags,
   output logic        overflow,
   output logic [7:0]  clip_count,
   output logic [15:0] pixels_written,
   output logic        collision
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, READ, CHECK, WRITE} state_t;

   state_t       state;
   logic [17:0]  mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         empty;
   logic         clipped;
   logic         push;
   logic         pop;
   logic [17:0]  head;
   logic [14:0]  head_addr;

   // The extra pointer bit tells a full buffer apart from an empty one when the indices match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign idle    = empty && (state == IDLE);
   assign clipped = ({1'b0, x_in} >= 9'(SCREEN_W)) || ({1'b0, y_in} >= 8'(SCREEN_H));
   assign push    = plot && !clipped && !full;
   assign pop     = (state == IDLE) && !empty;

   assign head      = mem[rd_ptr[AW-1:0]];
   assign head_addr = 15'(head[14:8]) * 15'(SCREEN_W) + 15'(head[7:0]);

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {colour_in, y_in, x_in};
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Clears win over a same-cycle clip or drop so software never loses a clear.
   always_ff @(posedge clock) begin
      if (!reset_n || clear_flags) begin
         overflow   <= 1'b0;
         clip_count <= '0;
      end else if (plot) begin
         if (clipped) begin
            if (clip_count != 8'hFF) begin
               clip_count <= clip_count + 8'd1;
            end
         end else if (full) begin
            overflow <= 1'b1;
         end
      end
   end

`ifdef COLLISION_DETECT_EN
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state          <= IDLE;
         fb_addr        <= '0;
         fb_wdata       <= '0;
         fb_we          <= 1'b0;
         fb_re          <= 1'b0;
         pixels_written <= '0;
         collision      <= 1'b0;
      end else begin
         if (clear_flags) begin
            collision <= 1'b0;
         end else if (state == CHECK && fb_rdata != 3'b000 && fb_wdata != 3'b000) begin
            collision <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (pop) begin
                  fb_addr  <= head_addr;
                  fb_wdata <= head[17:15];
                  fb_re    <= 1'b1;
                  state    <= READ;
               end
            end
            READ: begin
               if (fb_ready) begin
                  fb_re <= 1'b0;
                  state <= CHECK;
               end
            end
            CHECK: begin
               fb_we <= 1'b1;
               state <= WRITE;
            end
            WRITE: begin
               if (fb_ready) begin
                  fb_we          <= 1'b0;
                  pixels_written <= pixels_written + 16'd1;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   logic rdata_unused;

   assign fb_re        = 1'b0;
   assign collision    = 1'b0;
   assign rdata_unused = ^fb_rdata;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state          <= IDLE;
         fb_addr        <= '0;
         fb_wdata       <= '0;
         fb_we          <= 1'b0;
         pixels_written <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  fb_addr  <= head_addr;
                  fb_wdata <= head[17:15];
                  fb_we    <= 1'b1;
                  state    <= WRITE;
               end
            end
            WRITE: begin
               if (fb_ready) begin
                  fb_we          <= 1'b0;
                  pixels_written <= pixels_written + 16'd1;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_pixel_plot_sink.sv
// Randomised and directed bench for pixel_plot_sink with a queue-based reference model and write scoreboard.
// Covers the COLLISION_DETECT_EN build as well when that macro is defined.
module tb_pixel_plot_sink;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int DEPTH    = 8;
`ifdef COLLISION_DETECT_EN
   localparam bit COLL_EN = 1'b1;
`else
   localparam bit COLL_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_n;
   logic        plot;
   logic [7:0]  x_in;
   logic [6:0]  y_in;
   logic [2:0]  colour_in;
   logic        full;
   logic        idle;
   logic        fb_ready;
   logic [14:0] fb_addr;
   logic [2:0]  fb_wdata;
   logic        fb_we;
   logic        fb_re;
   logic [2:0]  fb_rdata;
   logic        clear_flags;
   logic        overflow;
   logic [7:0]  clip_count;
   logic [15:0] pixels_written;
   logic        collision;

   always #5 clock = ~clock;

   pixel_plot_sink #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset_n(reset_n), .plot(plot), .x_in(x_in), .y_in(y_in),
      .colour_in(colour_in), .full(full), .idle(idle), .fb_ready(fb_ready),
      .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_we(fb_we), .fb_re(fb_re),
      .fb_rdata(fb_rdata), .clear_flags(clear_flags), .overflow(overflow),
      .clip_count(clip_count), .pixels_written(pixels_written), .collision(collision)
   );

   typedef struct {
      int addr;
      int colour;
   } pix_t;

   typedef enum int {M_IDLE, M_READ, M_CHECK, M_WRITE} mstage_t;

   int      errors = 0;
   int      checks = 0;
   int      n_commits = 0;
   pix_t    model_fifo[$];
   pix_t    exp_writes[$];
   pix_t    m_held;
   pix_t    mon_pix;
   mstage_t m_stage = M_IDLE;
   int      m_overflow = 0;
   int      m_clip = 0;
   int      m_written = 0;
   int      m_collision = 0;
   bit      stalled = 1'b0;
   int      stall_addr;
   int      stall_data;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference behaviour of one clock edge, phrased in terms of a pixel queue and a held pixel.
   task automatic model_edge(input int p, input int x, input int y, input int c,
                             input int rdy, input int clr, input int rst, input int rdata);
      bit   pre_full;
      pix_t pix;
      if (rst == 0) begin
         model_fifo.delete();
         exp_writes.delete();
         m_stage     = M_IDLE;
         m_overflow  = 0;
         m_clip      = 0;
         m_written   = 0;
         m_collision = 0;
      end else begin
         pre_full = (model_fifo.size() == DEPTH);
         case (m_stage)
            M_IDLE: if (model_fifo.size() > 0) begin
               m_held  = model_fifo.pop_front();
               m_stage = COLL_EN ? M_READ : M_WRITE;
            end
            M_READ: if (rdy != 0) m_stage = M_CHECK;
            M_CHECK: begin
               if (rdata != 0 && m_held.colour != 0) m_collision = 1;
               m_stage = M_WRITE;
            end
            M_WRITE: if (rdy != 0) begin
               m_written = (m_written + 1) % 65536;
               m_stage   = M_IDLE;
            end
            default: m_stage = M_IDLE;
         endcase
         if (p != 0) begin
            if (x >= SCREEN_W || y >= SCREEN_H) begin
               if (m_clip < 255) m_clip++;
            end else if (pre_full) begin
               m_overflow = 1;
            end else begin
               pix.addr   = y * SCREEN_W + x;
               pix.colour = c;
               model_fifo.push_back(pix);
               exp_writes.push_back(pix);
            end
         end
         if (clr != 0) begin
            m_overflow  = 0;
            m_clip      = 0;
            m_collision = 0;
         end
      end
   endtask

   task automatic check_output();
      check("full", full, (model_fifo.size() == DEPTH) ? 1 : 0);
      check("idle", idle, (model_fifo.size() == 0 && m_stage == M_IDLE) ? 1 : 0);
      check("overflow", overflow, m_overflow);
      check("clip_count", clip_count, m_clip);
      check("pixels_written", pixels_written, m_written);
      check("fb_we", fb_we, (m_stage == M_WRITE) ? 1 : 0);
      check("fb_re", fb_re, (m_stage == M_READ) ? 1 : 0);
      check("collision", collision, m_collision);
   endtask

   // Drive one cycle of inputs, let the edge happen, advance the model and compare status.
   task automatic apply_stimulus(input int p, input int x, input int y, input int c,
                                 input int rdy, input int clr, input int rst);
      plot        = p[0];
      x_in        = 8'(x);
      y_in        = 7'(y);
      colour_in   = 3'(c);
      fb_ready    = rdy[0];
      clear_flags = clr[0];
      reset_n     = rst[0];
      @(posedge clock);
      model_edge(p, x, y, c, rdy, clr, rst, int'(fb_rdata));
      #1;
      check_output();
   endtask

   task automatic idle_cycles(input int n, input int rdy);
      for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, rdy, 0, 1);
   endtask

   // Scoreboard monitor: the write seen here commits on the following rising edge.
   always @(negedge clock) begin
      if (reset_n === 1'b1 && fb_we === 1'b1) begin
         if (stalled) begin
            check("stall_addr", fb_addr, stall_addr);
            check("stall_data", fb_wdata, stall_data);
         end
         if (fb_ready === 1'b1) begin
            stalled = 1'b0;
            n_commits++;
            if (exp_writes.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL write_order: unexpected write addr=%0d data=%0d, none queued", fb_addr, fb_wdata);
            end else begin
               mon_pix = exp_writes.pop_front();
               check("write_addr", fb_addr, mon_pix.addr);
               check("write_data", fb_wdata, mon_pix.colour);
            end
         end else begin
            stalled    = 1'b1;
            stall_addr = int'(fb_addr);
            stall_data = int'(fb_wdata);
         end
      end else begin
         stalled = 1'b0;
      end
   end

   initial begin
      int base;
      int rdy;
      fb_rdata = 3'b000;

      apply_stimulus(0, 0, 0, 0, 0, 0, 0);
      apply_stimulus(0, 0, 0, 0, 0, 0, 0);
      check("reset_addr", fb_addr, 0);
      check("reset_wdata", fb_wdata, 0);
      apply_stimulus(0, 0, 0, 0, 1, 0, 1);

      // Single pixel: popped one edge after the plot, write strobe follows.
      apply_stimulus(1, 10, 5, 4, 1, 0, 1);
      check("t0_fb_we", fb_we, 0);
      apply_stimulus(0, 0, 0, 0, 1, 0, 1);
      check("t1_addr", fb_addr, 810);
      check("t1_wdata", fb_wdata, 4);
`ifdef COLLISION_DETECT_EN
      check("t1_fb_re", fb_re, 1);
`else
      check("t1_fb_we", fb_we, 1);
`endif
      idle_cycles(4, 1);
      check("single_written", pixels_written, 1);
      check("single_idle", idle, 1);

      // Off-screen pixels are only counted.
      base = n_commits;
      apply_stimulus(1, 160, 0, 5, 1, 0, 1);
      apply_stimulus(1, 0, 120, 5, 1, 0, 1);
      idle_cycles(3, 1);
      check("clip_two", clip_count, 2);
      check("clip_no_overflow", overflow, 0);
      check("clip_no_write", n_commits - base, 0);

      // Stalled framebuffer: 1 held + 8 queued, the 10th plot is dropped.
      base = n_commits;
      for (int i = 0; i < 10; i++) apply_stimulus(1, i * 3, i + 1, (i % 7) + 1, 0, 0, 1);
      check("ovf_full", full, 1);
      check("ovf_flag", overflow, 1);
      idle_cycles(30, 1);
      check("ovf_commits", n_commits - base, 9);
      check("ovf_drained", exp_writes.size(), 0);

      // Grant toggling while a write is pending.
      base = n_commits;
      apply_stimulus(1, 77, 33, 6, 0, 0, 1);
      for (int i = 0; i < 8; i++) apply_stimulus(0, 0, 0, 0, i % 2, 0, 1);
      idle_cycles(4, 1);
      check("toggle_commits", n_commits - base, 1);

      // Reset while a write is stalled with 3 more pixels queued.
      apply_stimulus(1, 200, 0, 1, 0, 0, 1);
      for (int i = 0; i < 4; i++) apply_stimulus(1, 20 + i, 40, 2, 0, 0, 1);
      idle_cycles(2, 0);
      apply_stimulus(0, 0, 0, 0, 0, 0, 0);
      check("rst_fb_we", fb_we, 0);
      check("rst_idle", idle, 1);
      check("rst_clip", clip_count, 0);
      check("rst_written", pixels_written, 0);
      check("rst_overflow", overflow, 0);
      idle_cycles(2, 1);

      // Clip counter saturation and clear priority over a same-cycle clip.
      for (int i = 0; i < 260; i++) apply_stimulus(1, 160 + (i % 90), i % 128, 0, 1, 0, 1);
      check("clip_saturate", clip_count, 255);
      apply_stimulus(1, 250, 0, 0, 1, 1, 1);
      check("clip_clear", clip_count, 0);

`ifdef COLLISION_DETECT_EN
      fb_rdata = 3'b010;
      apply_stimulus(1, 1, 1, 1, 1, 0, 1);
      idle_cycles(6, 1);
      check("coll_set", collision, 1);
      apply_stimulus(0, 0, 0, 0, 1, 1, 1);
      check("coll_clear", collision, 0);
      apply_stimulus(1, 2, 2, 0, 1, 0, 1);
      idle_cycles(6, 1);
      check("coll_black", collision, 0);
`endif

      // Randomised traffic with alternating heavy and light framebuffer back-pressure.
      for (int i = 0; i < 800; i++) begin
         fb_rdata = 3'($urandom);
         if (((i / 100) % 2) == 0) rdy = ($urandom % 4 != 0) ? 1 : 0;
         else rdy = ($urandom % 4 == 0) ? 1 : 0;
         apply_stimulus(($urandom % 3 != 0) ? 1 : 0, $urandom_range(0, 175), $urandom_range(0, 127),
                        $urandom % 8, rdy, ($urandom % 60 == 0) ? 1 : 0, 1);
      end

      for (int i = 0; i < 60 && !(model_fifo.size() == 0 && m_stage == M_IDLE); i++) idle_cycles(1, 1);
      idle_cycles(2, 1);
      check("final_drained", exp_writes.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
